// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the datapath of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, WIDTH cycles per operation.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b (a + ~b + 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_co;

  full_adder u_full_adder (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtraction folds into addition: invert B once at capture, carry in of 1.
          b_d     = sub ? ~b : b;
          carry_d = sub;
`else
          b_d     = b;
          carry_d = 1'b0;
`endif
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8), plus multi-cycle corner sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_pass   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge: presents operands with start, returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'hC3;
    b     = 8'h3C;
  endtask

  // From the negedge after accept: W busy cycles, then a single done cycle with the result.
  task automatic finish_op(input string name, input logic [W-1:0] es, input logic ec);
    for (int i = 0; i < W; i++) begin
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " no_done"}, 32'(done), 32'd0);
      @(negedge clk);
    end
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " busy_in_done"}, 32'(busy), 32'd0);
    chk({name, " sum"}, 32'(sum), 32'(es));
    chk({name, " cout"}, 32'(cout), 32'(ec));
    $display("op %s: a/b -> sum=%02h cout=%0d", name, sum, cout);
    @(negedge clk);
    chk({name, " idle_after"}, 32'({busy, done}), 32'd0);
    chk({name, " sum_held"}, 32'(sum), 32'(es));
  endtask

  initial begin
    vec_t vecs[9];
    int   dcount;

    vecs[0] = '{"5A+33", 8'h5A, 8'h33, 8'h8D, 1'b0};
    vecs[1] = '{"FF+01", 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{"10+10", 8'h10, 8'h10, 8'h20, 1'b0};
    vecs[3] = '{"01+02", 8'h01, 8'h02, 8'h03, 1'b0};
    vecs[4] = '{"80+80", 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{"FF+FF", 8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[6] = '{"00+00", 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{"AA+55", 8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[8] = '{"7F+01", 8'h7F, 8'h01, 8'h80, 1'b0};

    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h33;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif

    // Reset held with start high: every output stays zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset sum", 32'(sum), 32'd0);
      chk("reset cout", 32'(cout), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset idle", 32'({busy, done}), 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      finish_op(vecs[i].name, vecs[i].sum, vecs[i].cout);
    end

    // start held through DONE: ignored in DONE, accepted on the following IDLE edge.
    issue(8'hFF, 8'h01);
    for (int i = 0; i < W; i++) @(negedge clk);
    chk("b2b done", 32'(done), 32'd1);
    chk("b2b sum", 32'(sum), 32'h00);
    chk("b2b cout", 32'(cout), 32'd1);
    a     = 8'h03;
    b     = 8'h04;
    start = 1'b1;
    @(negedge clk);
    chk("b2b idle_gap", 32'({busy, done}), 32'd0);
    chk("b2b sum_held", 32'(sum), 32'h00);
    @(negedge clk);
    start = 1'b0;
    finish_op("b2b second", 8'h07, 1'b0);

    // start with new operands during SHIFT is neither captured nor queued.
    issue(8'h10, 8'h10);
    for (int i = 0; i < W; i++) begin
      chk("ign busy", 32'(busy), 32'd1);
      if (i == 2) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end
      if (i == W - 1) start = 1'b0;
      @(negedge clk);
    end
    chk("ign done", 32'(done), 32'd1);
    chk("ign sum", 32'(sum), 32'h20);
    chk("ign cout", 32'(cout), 32'd0);
    dcount = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("ign extra_done", 32'(dcount), 32'd0);
    chk("ign sum_held", 32'(sum), 32'h20);

    // Asynchronous reset in the 4th SHIFT cycle abandons the op.
    issue(8'hFF, 8'hFF);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst sum", 32'(sum), 32'd0);
    chk("mid rst cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("mid no_activity", 32'(dcount), 32'd0);
    issue(8'h01, 8'h02);
    finish_op("after_rst", 8'h03, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    issue(8'h10, 8'h20);
    sub = 1'b0;
    finish_op("10-20", 8'hF0, 1'b0);
    sub = 1'b1;
    issue(8'h20, 8'h10);
    sub = 1'b0;
    finish_op("20-10", 8'h10, 1'b1);
    sub = 1'b1;
    issue(8'h05, 8'h05);
    sub = 1'b0;
    finish_op("05-05", 8'h00, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
